// File: rtl/counter_timer_if.sv
// Signal bundle between the interval timer, its host (config, control, interrupt)
// and the attached up-counter (d/load/enable out, q back in).
interface counter_timer_if #(
    parameter int WIDTH  = 4,
    parameter int MISS_W = 4
);
    logic              cfg_valid;
    logic [WIDTH-1:0]  cfg_period;
    logic              cfg_oneshot;
    logic              cfg_ready;
    logic              start;
    logic              stop;
    logic              irq_ack;
    logic [WIDTH-1:0]  cnt_q;
    logic [WIDTH-1:0]  cnt_d;
    logic              cnt_load;
    logic              cnt_enable;
    logic              running;
    logic              irq;
    logic [MISS_W-1:0] missed;

    modport master (
        output cfg_valid, cfg_period, cfg_oneshot, start, stop, irq_ack, cnt_q,
        input  cfg_ready, cnt_d, cnt_load, cnt_enable, running, irq, missed
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_oneshot, start, stop, irq_ack, cnt_q,
        output cfg_ready, cnt_d, cnt_load, cnt_enable, running, irq, missed
    );
endinterface

// File: rtl/counter_timer.sv
// Periodic / one-shot interval timer that steers an external counter and raises a
// sticky interrupt (with a saturating missed-tick count) when the counter hits the period.
module counter_timer #(
    parameter int MAX       = 16,
    parameter int WIDTH     = $clog2(MAX),
    parameter int CNT_DELAY = 0,
    parameter int MISS_W    = 4
) (
    input logic              i_clk,
    input logic              i_rst,
    counter_timer_if.slave   io_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_RUN,
        S_DONE
    } state_t;

    localparam int                GW         = (CNT_DELAY > 1) ? $clog2(CNT_DELAY) : 1;
    localparam logic [GW-1:0]     GUARD_INIT = (CNT_DELAY > 0) ? GW'(CNT_DELAY - 1) : '0;
    localparam logic [WIDTH-1:0]  PERIOD_RST = WIDTH'(MAX - 1);
    localparam logic [MISS_W-1:0] MISS_SAT   = '1;

    state_t            r_state;
    logic [GW-1:0]     r_guard_cnt;
    logic [WIDTH-1:0]  r_period;
    logic              r_oneshot;
    logic              r_pend_valid;
    logic [WIDTH-1:0]  r_pend_period;
    logic              r_pend_oneshot;
    logic              r_irq;
    logic [MISS_W-1:0] r_missed;

    logic              w_timing;
    logic              w_tick;
    logic              w_load;
    logic              w_enable;
    logic [WIDTH-1:0]  w_load_period;
    logic              w_load_oneshot;

    // GUARD covers the counter's q latency, so q is only trusted in RUN.
    assign w_timing = (r_state == S_RUN) || (r_state == S_GUARD);
    assign w_tick   = !i_rst && !io_bus.stop && (r_state == S_RUN) &&
                      (io_bus.cnt_q == r_period);
    assign w_load   = !i_rst && !io_bus.stop &&
                      (io_bus.start || (w_tick && !r_oneshot));
    assign w_enable = !i_rst && !io_bus.stop && !io_bus.start && !w_tick &&
                      (r_state == S_RUN);

    // A write arriving in the same cycle as a reload is the newest and wins over the pending one.
    assign w_load_period  = io_bus.cfg_valid ? io_bus.cfg_period
                          : (r_pend_valid ? r_pend_period : r_period);
    assign w_load_oneshot = io_bus.cfg_valid ? io_bus.cfg_oneshot
                          : (r_pend_valid ? r_pend_oneshot : r_oneshot);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_guard_cnt    <= '0;
            r_period       <= PERIOD_RST;
            r_oneshot      <= 1'b0;
            r_pend_valid   <= 1'b0;
            r_pend_period  <= PERIOD_RST;
            r_pend_oneshot <= 1'b0;
            r_irq          <= 1'b0;
            r_missed       <= '0;
        end else begin
            if (w_tick) begin
                r_irq <= 1'b1;
                if (io_bus.irq_ack) begin
                    r_missed <= '0;
                end else if (r_irq && (r_missed != MISS_SAT)) begin
                    r_missed <= r_missed + 1'b1;
                end
            end else if (io_bus.irq_ack) begin
                r_irq    <= 1'b0;
                r_missed <= '0;
            end

            if (w_load) begin
                r_period     <= w_load_period;
                r_oneshot    <= w_load_oneshot;
                r_pend_valid <= 1'b0;
            end else if (io_bus.cfg_valid) begin
                if (w_timing) begin
                    r_pend_valid   <= 1'b1;
                    r_pend_period  <= io_bus.cfg_period;
                    r_pend_oneshot <= io_bus.cfg_oneshot;
                end else begin
                    r_period     <= io_bus.cfg_period;
                    r_oneshot    <= io_bus.cfg_oneshot;
                    r_pend_valid <= 1'b0;
                end
            end

            if (io_bus.stop) begin
                r_state <= S_IDLE;
            end else if (w_load) begin
                r_state     <= (CNT_DELAY == 0) ? S_RUN : S_GUARD;
                r_guard_cnt <= GUARD_INIT;
            end else begin
                unique case (r_state)
                    S_GUARD: begin
                        if (r_guard_cnt == '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_guard_cnt <= r_guard_cnt - 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_tick) begin
                            r_state <= S_DONE;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign io_bus.cfg_ready  = 1'b1;
    assign io_bus.cnt_d      = '0;
    assign io_bus.cnt_load   = w_load;
    assign io_bus.cnt_enable = w_enable;
    assign io_bus.running    = w_timing;
    assign io_bus.irq        = r_irq;
    assign io_bus.missed     = r_missed;

endmodule

// File: tb/tb_counter_timer.sv
// Scoreboard bench for counter_timer: a behavioural timing model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT driving a modelled counter.
module tb_counter_timer;

    localparam int MAX      = 16;
    localparam int WIDTH    = 4;
    localparam int D        = 2;
    localparam int MISS_W   = 4;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    typedef struct {
        int                cyc;
        bit                check;
        logic              load;
        logic              enable;
        logic              running;
        logic              irq;
        logic [MISS_W-1:0] missed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_timer_if #(.WIDTH(WIDTH), .MISS_W(MISS_W)) bus ();

    counter_timer #(
        .MAX      (MAX),
        .WIDTH    (WIDTH),
        .CNT_DELAY(D),
        .MISS_W   (MISS_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    // Attached counter: load takes effect D cycles late, enable counts immediately.
    logic [WIDTH-1:0] cntVal;
    logic [D-1:0]     loadPipe;
    assign bus.cnt_q = cntVal;

    always @(posedge clk) begin
        if (rst) begin
            cntVal   <= '0;
            loadPipe <= '0;
        end else begin
            loadPipe <= {loadPipe[D-2:0], bus.cnt_load};
            if (loadPipe[D-1]) begin
                cntVal <= '0;
            end else if (bus.cnt_enable) begin
                cntVal <= cntVal + 1'b1;
            end
        end
    end

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;
    int   cyc      = 0;

    // Model: mode 0 idle, 1 timing, 2 done; ticks land P+1+D cycles after the last load.
    int   mMode    = 0;
    int   mLoadCyc = 0;
    int   mP       = MAX - 1;
    bit   mOs      = 1'b0;
    int   mLatP    = MAX - 1;
    bit   mLatOs   = 1'b0;
    bit   mIrq     = 1'b0;
    int   mMissed  = 0;
    bit   mValid   = 1'b0;

    function automatic bit tickNow(input bit iRst, input bit iStop);
        return !iRst && !iStop && (mMode == 1) && (cyc == mLoadCyc + mP + 1 + D);
    endfunction

    task automatic applyStimulus(input bit iRst, input bit iStart, input bit iStop,
                                 input bit iAck, input bit iCfgV, input int iCfgP,
                                 input bit iCfgOs);
        exp_t e;
        bit   tick;
        bit   load;
        int   oldMode;
        bit   oldIrq;
        @(posedge clk);
        #1;
        rst             = iRst;
        bus.start       = iStart;
        bus.stop        = iStop;
        bus.irq_ack     = iAck;
        bus.cfg_valid   = iCfgV;
        bus.cfg_period  = iCfgP[WIDTH-1:0];
        bus.cfg_oneshot = iCfgOs;

        tick = tickNow(iRst, iStop);
        load = !iRst && !iStop && (iStart || (tick && !mOs));

        e.cyc     = cyc;
        e.check   = mValid;
        e.load    = load;
        e.enable  = !iRst && !iStop && !iStart && !tick && (mMode == 1) &&
                    (cyc >= mLoadCyc + D + 1);
        e.running = (mMode == 1);
        e.irq     = mIrq;
        e.missed  = mMissed[MISS_W-1:0];
        expQ.push_back(e);
        started = 1'b1;

        if (iRst) begin
            mMode   = 0;
            mIrq    = 1'b0;
            mMissed = 0;
            mP      = MAX - 1;
            mOs     = 1'b0;
            mLatP   = MAX - 1;
            mLatOs  = 1'b0;
            mValid  = 1'b1;
        end else begin
            oldMode = mMode;
            oldIrq  = mIrq;
            if (tick) begin
                mIrq = 1'b1;
                if (iAck) mMissed = 0;
                else if (oldIrq && mMissed < MISS_MAX) mMissed = mMissed + 1;
            end else if (iAck) begin
                mIrq    = 1'b0;
                mMissed = 0;
            end
            if (iCfgV) begin
                mLatP  = iCfgP;
                mLatOs = iCfgOs;
                if (oldMode != 1) begin
                    mP  = iCfgP;
                    mOs = iCfgOs;
                end
            end
            if (iStop) begin
                mMode = 0;
            end else if (load) begin
                mMode    = 1;
                mLoadCyc = cyc;
                mP       = mLatP;
                mOs      = mLatOs;
            end else if (tick) begin
                mMode = 2;
            end
        end
        cyc++;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.cnt_load !== e.load || bus.cnt_enable !== e.enable ||
            bus.running !== e.running || bus.irq !== e.irq || bus.missed !== e.missed ||
            bus.cnt_d !== '0 || bus.cfg_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL outputs cyc=%0d got load=%b en=%b run=%b irq=%b missed=%0d d=%0d rdy=%b want load=%b en=%b run=%b irq=%b missed=%0d d=0 rdy=1",
                     e.cyc, bus.cnt_load, bus.cnt_enable, bus.running, bus.irq, bus.missed,
                     bus.cnt_d, bus.cfg_ready, e.load, e.enable, e.running, e.irq, e.missed);
        end
    endtask

    exp_t monE;
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            monE = expQ.pop_front();
            if (monE.check) checkOutput(monE);
        end else if (started) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty got 0 entries want 1");
        end
    end

    task automatic idleFor(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeCfg(input int p, input bit os);
        applyStimulus(0, 0, 0, 0, 1, p, os);
    endtask

    task automatic pulseStart();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic pulseStop();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic ackOnTick();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (tickNow(1'b0, 1'b0)) begin
                applyStimulus(0, 0, 0, 1, 0, 0, 0);
                done = 1'b1;
            end else begin
                idleFor(1);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_on_tick got no tick within 40 cycles want a tick");
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.irq_ack     = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_period  = '0;
        bus.cfg_oneshot = 1'b0;
        $display("[TB] counter_timer bench, CNT_DELAY=%0d", D);

        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Periodic P=3, then a period change mid-run that waits for the next reload.
        writeCfg(3, 0);
        pulseStart();
        idleFor(20);
        writeCfg(7, 0);
        idleFor(24);

        // One-shot P=5, then restart from DONE.
        pulseStop();
        writeCfg(5, 1);
        pulseStart();
        idleFor(12);
        pulseStart();
        idleFor(12);

        // P=0 periodic with no ack: missed saturates, then an ack landing on a tick.
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        writeCfg(0, 0);
        pulseStart();
        idleFor(65);
        ackOnTick();
        idleFor(6);

        // start+stop together stays idle; reset in the middle of a run.
        pulseStop();
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        idleFor(4);
        writeCfg(3, 0);
        pulseStart();
        idleFor(5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idleFor(4);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 999) < 4,
                          $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 6,
                          int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) == 0);
        end
        idleFor(2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
